pmp_scan_ctrl: RTL and testbench

Sequential PMP checker: one PMP entry evaluated per clock, lowest-numbered hit wins, so only one address comparator is needed.
Sits between the LSU/fetch request path and the PMP CSR bank. Uses a valid/ready request and response handshake.
Exports cfg_busy so the CSR write path stalls pmpcfg/pmpaddr writes while a scan is in flight.

---
 rtl/pmp_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pmp_scan_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_scan_ctrl.sv
// pmp_scan_ctrl
//   Sequential PMP checker. A captured request is compared against one PMP
//   entry per clock, starting at entry 0. The first (lowest-numbered) entry
//   whose region touches the access decides the result, so only one region
//   comparator is needed.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   pmpcfg_flat    : entry i cfg byte at [8i+7:8i] (L, A[1:0], X, W, R)
//   pmpaddr_flat   : entry i pmpaddr at [32i+31:32i] (byte address bits 33:2)
//   req_*          : request handshake; addr/size/oper/priv captured in IDLE
//   resp_*         : result handshake; perm 11 = granted, else captured oper
//   cfg_busy       : high while a request is in flight (SCAN or RESP)
module pmp_scan_ctrl #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*N_ENTRIES-1:0]   pmpcfg_flat,
    input  logic [32*N_ENTRIES-1:0]  pmpaddr_flat,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [1:0]               req_size,
    input  logic [1:0]               req_oper,
    input  logic [1:0]               req_priv,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [1:0]               resp_perm,
    output logic                     resp_hit,
    output logic [IDX_W-1:0]         resp_idx,
    output logic                     cfg_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cap_addr;
    logic [1:0]       cap_size;
    logic [1:0]       cap_oper;
    logic [1:0]       cap_priv;

    // Per-entry views of the flat CSR buses.
    logic [7:0]              cfg_arr [N_ENTRIES];
    logic [31:0]             pa_arr  [N_ENTRIES];
    logic [2*N_ENTRIES-1:0]  rsvd_unused;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_unpack
        assign cfg_arr[g]             = pmpcfg_flat[8*g +: 8];
        assign pa_arr[g]              = pmpaddr_flat[32*g +: 32];
        // cfg bits 6:5 are reserved and carry no function here.
        assign rsvd_unused[2*g +: 2]  = pmpcfg_flat[8*g+5 +: 2];
    end

    logic [7:0]  cur_cfg;
    logic [31:0] cur_pa;
    logic [31:0] prev_pa;

    assign cur_cfg = cfg_arr[idx];
    assign cur_pa  = pa_arr[idx];
    assign prev_pa = (idx == '0) ? '0 : pa_arr[idx - 1'b1];

    // Access byte range; size 11 behaves as a word.
    logic [1:0]  eff_size;
    logic [32:0] acc_lo;
    logic [32:0] acc_hi;
    logic        acc_wrap;

    assign eff_size = (cap_size == 2'b11) ? 2'b10 : cap_size;
    assign acc_lo   = {1'b0, cap_addr};
    assign acc_hi   = acc_lo + ((33'd1 << eff_size) - 33'd1);
    assign acc_wrap = acc_hi[32];

    // Region as [reg_base, reg_top) in 36 bits so that an all-ones NAPOT
    // entry (2^35 bytes) is representable.
    logic [32:0] napot_mask;
    logic [35:0] reg_base;
    logic [35:0] reg_top;
    logic        reg_on;

    // pa ^ (pa+1) yields 2^(t+1)-1 where t = number of trailing ones.
    assign napot_mask = {1'b0, cur_pa} ^ ({1'b0, cur_pa} + 33'd1);

    always_comb begin
        reg_base = '0;
        reg_top  = '0;
        reg_on   = 1'b0;
        case (cur_cfg[4:3])
            2'b01: begin
                reg_base = {2'b00, prev_pa, 2'b00};
                reg_top  = {2'b00, cur_pa, 2'b00};
                reg_on   = (reg_base < reg_top);
            end
            2'b10: begin
                reg_base = {2'b00, cur_pa, 2'b00};
                reg_top  = reg_base + 36'd4;
                reg_on   = 1'b1;
            end
            2'b11: begin
                reg_base = {1'b0, ({1'b0, cur_pa} & ~napot_mask), 2'b00};
                reg_top  = reg_base + ({1'b0, napot_mask, 2'b00} + 36'd4);
                reg_on   = 1'b1;
            end
            default: ;
        endcase
    end

    logic [35:0] lo36;
    logic [35:0] hi36;
    logic        overlap;
    logic        contained;

    assign lo36      = {3'b000, acc_lo};
    assign hi36      = {3'b000, acc_hi};
    assign overlap   = reg_on && (lo36 < reg_top) && (hi36 >= reg_base);
    assign contained = (lo36 >= reg_base) && (hi36 < reg_top);

    logic       perm_bit;
    logic [1:0] hit_perm;
    logic [1:0] nohit_perm;

    always_comb begin
        perm_bit = 1'b0;
        case (cap_oper)
            2'b00:   perm_bit = cur_cfg[0];
            2'b01:   perm_bit = cur_cfg[1];
            2'b10:   perm_bit = cur_cfg[2];
            default: perm_bit = 1'b0;
        endcase

        hit_perm = cap_oper;
        if (contained) begin
            if (cap_priv == 2'b11 && !cur_cfg[7]) begin
                hit_perm = 2'b11;
            end else if (perm_bit) begin
                hit_perm = 2'b11;
            end
        end
    end

    assign nohit_perm = (cap_priv == 2'b11) ? 2'b11 : cap_oper;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cap_addr   <= '0;
            cap_size   <= '0;
            cap_oper   <= '0;
            cap_priv   <= '0;
            resp_valid <= 1'b0;
            resp_perm  <= '0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_addr <= req_addr;
                        cap_size <= req_size;
                        cap_oper <= req_oper;
                        cap_priv <= req_priv;
                        idx      <= '0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (acc_wrap) begin
                        // A wrapping access can never be legal; deny on the
                        // first scan cycle without consulting any entry.
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_perm  <= cap_oper;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (overlap) begin
                        resp_hit   <= 1'b1;
                        resp_idx   <= idx;
                        resp_perm  <= hit_perm;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (idx == LAST_IDX) begin
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_perm  <= nohit_perm;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign cfg_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// tb_pmp_scan_ctrl
//   Self-checking bench for pmp_scan_ctrl. A behavioural reference computes
//   each request's outcome (hit, index, permission, latency) directly from
//   the PMP rules; a protocol model tracks when the DUT must be idle, busy or
//   presenting a response, and a compare process checks every cycle.
module tb_pmp_scan_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*N-1:0]   pmpcfg_flat;
    logic [32*N-1:0]  pmpaddr_flat;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic [1:0]       req_oper;
    logic [1:0]       req_priv;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_perm;
    logic             resp_hit;
    logic [IW-1:0]    resp_idx;
    logic             cfg_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmp_scan_ctrl #(.N_ENTRIES(N), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmpcfg_flat  (pmpcfg_flat),
        .pmpaddr_flat (pmpaddr_flat),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_oper     (req_oper),
        .req_priv     (req_priv),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_perm    (resp_perm),
        .resp_hit     (resp_hit),
        .resp_idx     (resp_idx),
        .cfg_busy     (cfg_busy)
    );

    // Reference outcome of one request. lat = clock edges from acceptance
    // until resp_valid is visible.
    task automatic model_eval(input logic [8*N-1:0] cf, input logic [32*N-1:0] ad,
                              input logic [31:0] addr, input logic [1:0] size,
                              input logic [1:0] oper, input logic [1:0] priv,
                              output int hit, output int idx, output int perm,
                              output int lat);
        longint lo, hi, b, t, pa, blk;
        int     sz, tz;
        logic [7:0] c;
        bit     found;
        sz   = (size == 2'd3) ? 2 : int'(size);
        lo   = longint'(addr);
        hi   = lo + (longint'(1) << sz) - 1;
        hit  = 0;
        idx  = 0;
        lat  = N;
        perm = (priv == 2'd3) ? 3 : int'(oper);
        if (hi > longint'(64'hFFFF_FFFF)) begin
            perm = int'(oper);
            lat  = 1;
            return;
        end
        found = 0;
        for (int i = 0; i < N && !found; i++) begin
            c  = cf[8*i +: 8];
            pa = longint'(ad[32*i +: 32]);
            b  = 0;
            t  = 0;
            case (c[4:3])
                2'd1: begin
                    if (i > 0) b = longint'(ad[32*(i-1) +: 32]) * 4;
                    t = pa * 4;
                end
                2'd2: begin
                    b = pa * 4;
                    t = b + 4;
                end
                2'd3: begin
                    tz = 0;
                    while (tz < 32 && pa[tz]) tz++;
                    blk = longint'(1) << (tz + 3);
                    b   = ((pa * 4) / blk) * blk;
                    t   = b + blk;
                end
                default: ;
            endcase
            if (b < t && lo < t && hi >= b) begin
                found = 1;
                hit   = 1;
                idx   = i;
                lat   = i + 1;
                if (!(lo >= b && hi < t))          perm = int'(oper);
                else if (priv == 2'd3 && !c[7])    perm = 3;
                else if (oper != 2'd3 && c[oper])  perm = 3;
                else                               perm = int'(oper);
            end
        end
    endtask

    // Protocol model: 0 idle, 1 scanning, 2 response presented.
    int m_phase = 0;
    int m_wait  = 0;
    int m_hit   = 0;
    int m_idx   = 0;
    int m_perm  = 0;

    always @(posedge clk) begin
        int h, ix, p, l;
        if (rst) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    model_eval(pmpcfg_flat, pmpaddr_flat, req_addr, req_size,
                               req_oper, req_priv, h, ix, p, l);
                    m_hit   <= h;
                    m_idx   <= ix;
                    m_perm  <= p;
                    m_wait  <= l - 1;
                    m_phase <= 1;
                end
                1: if (m_wait == 0) m_phase <= 2;
                   else m_wait <= m_wait - 1;
                2: if (resp_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (req_ready !== (m_phase == 0) || cfg_busy !== (m_phase != 0) ||
                resp_valid !== (m_phase == 2)) begin
                errors++;
                $display("FAIL handshake @%0t: ready=%b busy=%b valid=%b, required %b %b %b",
                         $time, req_ready, cfg_busy, resp_valid,
                         m_phase == 0, m_phase != 0, m_phase == 2);
            end
            if (m_phase == 2) begin
                checks++;
                if (resp_hit !== m_hit[0] || resp_idx !== IW'(m_idx) ||
                    resp_perm !== 2'(m_perm)) begin
                    errors++;
                    $display("FAIL result @%0t: hit=%b idx=%0d perm=%b, required hit=%0d idx=%0d perm=%0d",
                             $time, resp_hit, resp_idx, resp_perm, m_hit, m_idx, m_perm);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
        pmpcfg_flat[8*i +: 8]   = c;
        pmpaddr_flat[32*i +: 32] = a;
    endtask

    task automatic clear_all();
        pmpcfg_flat  = '0;
        pmpaddr_flat = '0;
    endtask

    // Pins the reference against hand-derived values.
    task automatic pin(input string nm, input logic [31:0] a, input logic [1:0] s,
                       input logic [1:0] o, input logic [1:0] p,
                       input int eh, input int ei, input int ep, input int el);
        int h, i, pp, l;
        model_eval(pmpcfg_flat, pmpaddr_flat, a, s, o, p, h, i, pp, l);
        checks++;
        if (h != eh || i != ei || pp != ep || l != el) begin
            errors++;
            $display("FAIL pin_%s: hit=%0d idx=%0d perm=%0d lat=%0d, required %0d %0d %0d %0d",
                     nm, h, i, pp, l, eh, ei, ep, el);
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [1:0] s, input logic [1:0] o,
                           input logic [1:0] p, input int hold, input bit poke);
        bit ok;
        req_addr  = a;
        req_size  = s;
        req_oper  = o;
        req_priv  = p;
        req_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            if (req_ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
            return;
        end
        ok = 0;
        for (int n = 0; n < N + 5; n++) begin
            if (resp_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid=%b, required 1", resp_valid);
        end
        for (int n = 0; n < hold; n++) begin
            if (poke) req_valid = (n == 1);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (req_ready !== 1'b1 || cfg_busy !== 1'b0 || resp_valid !== 1'b0 ||
            resp_hit !== 1'b0 || resp_idx !== '0 || resp_perm !== 2'b00) begin
            errors++;
            $display("FAIL %s: ready=%b busy=%b valid=%b hit=%b idx=%0d perm=%b, required 1 0 0 0 0 00",
                     nm, req_ready, cfg_busy, resp_valid, resp_hit, resp_idx, resp_perm);
        end
    endtask

    task automatic random_config();
        logic [7:0]  c;
        logic [31:0] pa;
        int          mode, t;
        for (int i = 0; i < N; i++) begin
            mode = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
            pa   = 32'($urandom_range(0, 32'h7FF));
            if (mode == 3) begin
                t  = int'($urandom_range(0, 8));
                pa = (pa & ~((32'd1 << (t + 1)) - 32'd1)) | ((32'd1 << t) - 32'd1);
                if ($urandom_range(0, 39) == 0) pa = 32'hFFFF_FFFF;
            end
            c = {1'($urandom_range(0, 1)), 2'b00, 2'(mode), 3'($urandom_range(0, 7))};
            set_entry(i, c, pa);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rp;
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_oper   = '0;
        req_priv   = '0;
        clear_all();
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset_state");

        // TOR entry 0 covering [0, 0x1000)
        set_entry(0, 8'h0B, 32'h0000_0400);
        pin("tor_u_read", 32'h800, 2'd2, 2'd0, 2'd0, 1, 0, 3, 1);
        run_req(32'h800, 2'd2, 2'd0, 2'd0, 0, 0);
        pin("partial_m", 32'hFFE, 2'd2, 2'd0, 2'd3, 1, 0, 0, 1);
        run_req(32'hFFE, 2'd2, 2'd0, 2'd3, 1, 0);

        // NAPOT entry 3, 4 KB at 0x8000_0000, with backpressure
        clear_all();
        set_entry(3, 8'h9C, 32'h2000_01FF);
        pin("napot_locked", 32'h8000_0010, 2'd2, 2'd1, 2'd3, 1, 3, 1, 4);
        run_req(32'h8000_0010, 2'd2, 2'd1, 2'd3, 3, 1);
        set_entry(3, 8'h1C, 32'h2000_01FF);
        pin("napot_unlocked", 32'h8000_0010, 2'd2, 2'd1, 2'd3, 1, 3, 3, 4);
        run_req(32'h8000_0010, 2'd2, 2'd1, 2'd3, 0, 0);

        // all entries off
        clear_all();
        pin("off_u_exec", 32'h1234, 2'd2, 2'd2, 2'd0, 0, 0, 2, 16);
        run_req(32'h1234, 2'd2, 2'd2, 2'd0, 0, 0);
        pin("off_m_exec", 32'h1234, 2'd2, 2'd2, 2'd3, 0, 0, 3, 16);
        run_req(32'h1234, 2'd2, 2'd2, 2'd3, 2, 0);

        // overlapping NA4 (entry 1) and NAPOT (entry 2): lowest wins
        set_entry(1, 8'h13, 32'h0000_0100);
        set_entry(2, 8'h1F, 32'h0000_01FF);
        pin("overlap", 32'h400, 2'd2, 2'd0, 2'd0, 1, 1, 3, 2);
        run_req(32'h400, 2'd2, 2'd0, 2'd0, 0, 0);

        // wrapping access is denied without a hit
        pin("wrap", 32'hFFFF_FFFE, 2'd2, 2'd0, 2'd3, 0, 0, 0, 1);
        run_req(32'hFFFF_FFFE, 2'd2, 2'd0, 2'd3, 0, 0);

        // all-ones NAPOT covers the whole space; U read with R=0 denied
        clear_all();
        set_entry(0, 8'h18, 32'hFFFF_FFFF);
        pin("napot_all", 32'hFFFF_FFF0, 2'd3, 2'd0, 2'd0, 1, 0, 0, 1);
        run_req(32'hFFFF_FFF0, 2'd3, 2'd0, 2'd0, 0, 0);

        // reset in the middle of a full-length scan
        clear_all();
        req_addr  = 32'h1234;
        req_size  = 2'd2;
        req_oper  = 2'd2;
        req_priv  = 2'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("reset_mid_scan");
        set_entry(0, 8'h0B, 32'h0000_0400);
        run_req(32'h800, 2'd2, 2'd0, 2'd0, 0, 0);

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            if (it % 10 == 0) random_config();
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                            ra = 32'($urandom_range(0, 32'h2100));
            rp = 2'($urandom_range(0, 3));
            run_req(ra, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rp,
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
